key_event_gen: RTL
==================

# key_event_gen

Button conditioning stage that sits between the board push-buttons and the per-device test harnesses in the test frame. The harnesses take their `cs`/`we`/`high` strobes from it. Each of N raw, asynchronous button inputs is synchronised and debounced. The block produces a clean level, single-cycle press and release pulses, and a keyboard-style auto-repeat strobe. Channels are fully independent and share only the clock and reset.

## Interface
- `CLK_FREQ`, default 10: clock frequency in MHz.
- `N`, default 4: number of button channels.
- `DEBOUNCE_US`, default 10000: time in µs the input must hold a new value before it is accepted. `D = CLK_FREQ*DEBOUNCE_US` cycles; D ≥ 1.
- `REPEAT_DELAY_US`, default 500000: hold time in µs from press to the first auto-repeat. `P = CLK_FREQ*REPEAT_DELAY_US` cycles; P ≥ 1.
- `REPEAT_RATE_US`, default 100000: interval in µs between subsequent auto-repeats. `R = CLK_FREQ*REPEAT_RATE_US` cycles; R ≥ 1.

- `clk`, input, 1: system clock. All logic is on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `btn_i`, input, N: raw button levels, asynchronous, active-high.
- `btn_o`, output, N: debounced level.
- `press`, output, N: one-cycle pulse on an accepted 0→1 transition.
- `release`, output, N: one-cycle pulse on an accepted 1→0 transition.
- `repeat`, output, N: one-cycle pulse on press and on each auto-repeat.

## Operation
- Reset (async assert, sync release): synchronisers, stable levels, counters and FSMs are cleared. All outputs are 0 and all FSMs are in IDLE.
- Synchroniser: two flops per channel. `sync` is `btn_i` delayed by 2 edges.
- Debounce, per channel: `cnt` has width `$clog2(D+1)`.
  - If `sync == btn_o`, `cnt` is cleared.
  - Otherwise `cnt` increments.
  - When `sync` has differed from `btn_o` for D consecutive cycles, `btn_o` takes the new value and `cnt` clears.
  - Any return to agreement before that clears `cnt`, so a glitch shorter than D cycles is discarded.
- Event outputs are registered in the same update as `btn_o`:
  - `press` and `repeat` are high during the first cycle `btn_o` = 1.
  - `release` is high during the first cycle `btn_o` = 0.
- Repeat FSM, per channel, with states IDLE, DELAY, REPEAT. The timer width is `$clog2(max(P,R))`.
  - IDLE: on accepted rise, go to DELAY and load timer = P-1.
  - DELAY: decrement the timer. At 0, pulse `repeat`, go to REPEAT and load timer = R-1.
  - REPEAT: decrement the timer. At 0, pulse `repeat` and reload R-1.
  - DELAY or REPEAT: on accepted fall, go to IDLE with no `repeat` pulse. The fall takes priority over a timer expiry in the same cycle.
- `press` and `release` are never high together on one channel. `repeat` is never high while `btn_o` = 0.
- Channels do not interact. Simultaneous presses on all channels produce simultaneous pulses.

## Timing
- Input to `btn_o` latency: if `btn_i` changes before edge 0 and stays, `btn_o` and its event pulse appear after edge 2+D. The sync delay is 2 edges and the debounce takes D edges.
- First auto-repeat is P cycles after the `press` cycle. Later repeats follow every R cycles.
- All pulses are exactly 1 cycle wide.
- Minimum accepted pulse width on `btn_i` is D cycles (plus metastability slack).
- Reset asserted mid-debounce or mid-repeat clears everything immediately. A button still held after release of reset is re-accepted after 2+D cycles, with a fresh `press`.

## Test plan
Bench parameters: CLK_FREQ=1, N=4, DEBOUNCE_US=4, REPEAT_DELAY_US=20, REPEAT_RATE_US=8 (so D=4, P=20, R=8).
- Reset: hold `rst_n`=0 with `btn_i`=4'hF, then release. All outputs are 0 until cycle 6 after release. At cycle 6, `btn_o`=4'hF and `press`=`repeat`=4'hF for 1 cycle.
- Clean press on bit 0 at cycle 0, held for 60 cycles:
  - `press[0]` at cycle 6.
  - `repeat[0]` at 6, 26, 34, 42, 50, 58.
  - Release is accepted 6 cycles after `btn_i` falls, giving one `release[0]` pulse and no further `repeat[0]`.
- Glitches: bit 1 pulses high for 3 cycles, low 1, high 3. There is no `btn_o[1]` change and no pulse. A 4-cycle high pulse yields `press[1]` and, 4 stable-low cycles later, `release[1]`.
- Release during DELAY: press bit 2, then release so the fall is accepted 10 cycles after `press[2]`. The response is `release[2]` only, with no auto-repeat, and the FSM returns to IDLE.
- Simultaneous and independent channels: bits 0 and 3 rise on the same cycle and bit 3 falls 30 cycles later. `press` = 4'b1001 in one cycle. Bit 0 keeps repeating at the R period after bit 3's `release`.
- Reset mid-repeat: assert `rst_n`=0 in REPEAT for 1 cycle with the button held. Outputs clear immediately, then `press` follows 6 cycles after reset release.

Source files
------------

// File: rtl/key_event_gen.sv
// key_event_gen: per-channel push-button conditioner.
// Each raw input goes through a two-flop synchroniser and a debounce counter.
// Accepted edges produce one-cycle press/release pulses. A keyboard-style
// auto-repeat strobe fires on press, again after a hold delay, and then at a
// fixed rate while the button stays down.
// The release/repeat strobes are named release_pulse/repeat_pulse because
// "release" and "repeat" are reserved words in SystemVerilog.
module key_event_gen #(
  parameter int CLK_FREQ        = 10,
  parameter int N               = 4,
  parameter int DEBOUNCE_US     = 10000,
  parameter int REPEAT_DELAY_US = 500000,
  parameter int REPEAT_RATE_US  = 100000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] btn_i,
  output logic [N-1:0] btn_o,
  output logic [N-1:0] press,
  output logic [N-1:0] release_pulse,
  output logic [N-1:0] repeat_pulse
);

  localparam int D      = CLK_FREQ * DEBOUNCE_US;
  localparam int P      = CLK_FREQ * REPEAT_DELAY_US;
  localparam int R      = CLK_FREQ * REPEAT_RATE_US;
  localparam int PR_MAX = (P > R) ? P : R;
  localparam int CW     = $clog2(D + 1);
  localparam int TW     = (PR_MAX > 1) ? $clog2(PR_MAX) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_REPEAT
  } state_t;

  logic [N-1:0] meta;
  logic [N-1:0] sync;

  // Two-flop synchroniser for the asynchronous button inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= btn_i;
      sync <= meta;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_ch
    logic [CW-1:0] cnt;
    logic          lvl;
    logic          prs;
    logic          rls;
    logic          rpt;
    logic          differ;
    logic          accept;
    logic          rise;
    logic          fall;
    state_t        state;
    state_t        state_next;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_next;
    logic          rpt_next;

    // A change is accepted on the D-th consecutive sample that disagrees
    // with the stable level; rise/fall are that same-edge decision.
    assign differ = sync[g] ^ lvl;
    assign accept = differ && (cnt == CW'(D - 1));
    assign rise   = accept && sync[g];
    assign fall   = accept && !sync[g];

    // Debounce counter, stable level and registered press/release pulses.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
        lvl <= 1'b0;
        prs <= 1'b0;
        rls <= 1'b0;
      end else begin
        prs <= rise;
        rls <= fall;
        if (!differ || accept) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
        if (accept) begin
          lvl <= sync[g];
        end
      end
    end

    // Auto-repeat state, timer and registered repeat strobe.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= S_IDLE;
        timer <= '0;
        rpt   <= 1'b0;
      end else begin
        state <= state_next;
        timer <= timer_next;
        rpt   <= rpt_next;
      end
    end

    // Auto-repeat next state: an accepted fall beats a same-cycle expiry.
    always_comb begin
      state_next = state;
      timer_next = timer;
      rpt_next   = 1'b0;
      unique case (state)
        S_IDLE: begin
          if (rise) begin
            state_next = S_DELAY;
            timer_next = TW'(P - 1);
            rpt_next   = 1'b1;
          end
        end
        S_DELAY: begin
          if (fall) begin
            state_next = S_IDLE;
          end else if (timer == '0) begin
            state_next = S_REPEAT;
            timer_next = TW'(R - 1);
            rpt_next   = 1'b1;
          end else begin
            timer_next = timer - 1'b1;
          end
        end
        S_REPEAT: begin
          if (fall) begin
            state_next = S_IDLE;
          end else if (timer == '0) begin
            timer_next = TW'(R - 1);
            rpt_next   = 1'b1;
          end else begin
            timer_next = timer - 1'b1;
          end
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase
    end

    assign btn_o[g]         = lvl;
    assign press[g]         = prs;
    assign release_pulse[g] = rls;
    assign repeat_pulse[g]  = rpt;
  end

endmodule
